// File: rtl/gen_buffer_pkg.sv
// Shared types for the circular-buffer scan engine: FSM state encoding and
// output FIFO sizing.
package gen_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int OFIFO_DEPTH = 3;
  localparam int OFIFO_OCC_W = $clog2(OFIFO_DEPTH + 1);
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH);

  function automatic logic [OFIFO_PTR_W-1:0] ofifo_ptr_inc(input logic [OFIFO_PTR_W-1:0] p);
    return (p == OFIFO_PTR_W'(OFIFO_DEPTH - 1)) ? '0 : p + OFIFO_PTR_W'(1);
  endfunction

endpackage

// File: rtl/gen_buffer_reader_ofifo.sv
// Small synchronous FIFO holding {last, data} between the buffer read port
// and the output stream; flush empties it in one cycle.
module gen_buffer_reader_ofifo
  import gen_buffer_pkg::*;
#(
  parameter int W = 9
) (
  input  logic                   clk,
  input  logic                   sw_rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head,
  output logic [OFIFO_OCC_W-1:0] occ,
  output logic                   empty
);

  logic [W-1:0]           mem_q [OFIFO_DEPTH];
  logic [W-1:0]           mem_d [OFIFO_DEPTH];
  logic [OFIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OFIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OFIFO_OCC_W-1:0] occ_q, occ_d;
  logic                   do_push;
  logic                   do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    do_push  = push && (occ_q != OFIFO_OCC_W'(OFIFO_DEPTH));
    do_pop   = pop && (occ_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ofifo_ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ofifo_ptr_inc(rd_ptr_q);
      end
      occ_d = occ_q + OFIFO_OCC_W'(do_push) - OFIFO_OCC_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      for (int i = 0; i < OFIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign occ   = occ_q;
  assign empty = (occ_q == '0);

endmodule

// File: rtl/gen_buffer_reader.sv
// Whole-buffer scan engine: snapshots fullness on start, reads every element
// through the 1-clk buffer port and streams them out with a last marker.
// Build option GEN_BUFFER_READER_REVERSE_EN scans newest element first.
//
// state    | meaning
// ST_IDLE  | waiting for start; zero-fullness start only pulses done
// ST_SCAN  | issuing one read per cycle while FIFO room and no writer add
// ST_DRAIN | all reads issued; waiting for the last element to be accepted
module gen_buffer_reader
  import gen_buffer_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int DEPTH       = 100,
  localparam int DEPTH_W     = $clog2(DEPTH + 1),
  localparam int DEPTH_IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   sw_rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DEPTH_W-1:0]     buf_fullness,
  input  logic                   buf_add_elem_req,
  output logic                   rd_elem_req,
  output logic [DEPTH_IDX_W-1:0] rd_elem_idx,
  input  logic [DATA_W-1:0]      buf_o_data,
  output logic                   o_valid,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_last,
  input  logic                   o_ready,
  output logic                   busy,
  output logic                   done
);

  state_e                 state_q, state_d;
  logic [DEPTH_W-1:0]     cnt_q, cnt_d;
  logic [DEPTH_W-1:0]     issued_q, issued_d;
  logic [DEPTH_IDX_W-1:0] idx_q, idx_d;
  logic                   inflight_q, inflight_d;
  logic                   infl_last_q, infl_last_d;
  logic                   zdone_q, zdone_d;

  logic                   issue;
  logic                   last_issue;
  logic                   cancel;
  logic                   finish;
  logic [2:0]             fill_lvl;
  logic                   f_pop;
  logic [DATA_W:0]        f_head;
  logic [OFIFO_OCC_W-1:0] f_occ;
  logic                   f_empty;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    issued_d    = issued_q;
    idx_d       = idx_q;
    infl_last_d = infl_last_q;
    zdone_d     = 1'b0;

    // Occupancy-plus-inflight keeps room for the read already on its way back.
    fill_lvl   = 3'({1'b0, f_occ}) + 3'({2'b00, inflight_q});
    issue      = (state_q == ST_SCAN) && !buf_add_elem_req && (fill_lvl < 3'(OFIFO_DEPTH));
    last_issue = issue && ((issued_q + DEPTH_W'(1)) == cnt_q);
    cancel     = abort && (state_q != ST_IDLE);
    f_pop      = o_ready && !f_empty;
    finish     = (state_q == ST_DRAIN) && f_pop && f_head[DATA_W] && !abort;
    inflight_d = issue && !cancel;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (buf_fullness != '0) begin
            state_d  = ST_SCAN;
            cnt_d    = buf_fullness;
            issued_d = '0;
`ifdef GEN_BUFFER_READER_REVERSE_EN
            idx_d    = DEPTH_IDX_W'(buf_fullness - DEPTH_W'(1));
`else
            idx_d    = '0;
`endif
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (issue) begin
          issued_d    = issued_q + DEPTH_W'(1);
          infl_last_d = last_issue;
          if (last_issue) begin
            state_d = ST_DRAIN;
          end else begin
`ifdef GEN_BUFFER_READER_REVERSE_EN
            idx_d = idx_q - DEPTH_IDX_W'(1);
`else
            idx_d = idx_q + DEPTH_IDX_W'(1);
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (abort || finish) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      issued_q    <= '0;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      issued_q    <= issued_d;
      idx_q       <= idx_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      zdone_q     <= zdone_d;
    end
  end

  // A read issued in the abort cycle returns after the flush and is dropped
  // because inflight_q is cleared alongside it.
  gen_buffer_reader_ofifo #(
    .W (DATA_W + 1)
  ) u_ofifo (
    .clk       (clk),
    .sw_rst    (sw_rst),
    .push      (inflight_q),
    .push_data ({infl_last_q, buf_o_data}),
    .pop       (f_pop),
    .flush     (cancel),
    .head      (f_head),
    .occ       (f_occ),
    .empty     (f_empty)
  );

  assign rd_elem_req = issue;
  assign rd_elem_idx = idx_q;
  assign o_valid     = !f_empty;
  assign o_data      = f_empty ? '0 : f_head[DATA_W-1:0];
  assign o_last      = !f_empty && f_head[DATA_W];
  assign busy        = (state_q != ST_IDLE);
  assign done        = zdone_q || finish;

endmodule

// File: tb/tb_gen_buffer_reader.sv
// Bench for gen_buffer_reader: table of scan scenarios plus abort and
// mid-scan reset sequences, with an output scoreboard and read-order checker.
module tb_gen_buffer_reader;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 100;
  localparam int DEPTH_W     = $clog2(DEPTH + 1);
  localparam int DEPTH_IDX_W = $clog2(DEPTH);
`ifdef GEN_BUFFER_READER_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   sw_rst, start, abort, buf_add_elem_req, o_ready;
  logic [DEPTH_W-1:0]     buf_fullness;
  logic                   rd_elem_req;
  logic [DEPTH_IDX_W-1:0] rd_elem_idx;
  logic [DATA_W-1:0]      buf_o_data;
  logic                   o_valid, o_last, busy, done;
  logic [DATA_W-1:0]      o_data;

  always #5 clk = ~clk;

  gen_buffer_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .sw_rst           (sw_rst),
    .start            (start),
    .abort            (abort),
    .buf_fullness     (buf_fullness),
    .buf_add_elem_req (buf_add_elem_req),
    .rd_elem_req      (rd_elem_req),
    .rd_elem_idx      (rd_elem_idx),
    .buf_o_data       (buf_o_data),
    .o_valid          (o_valid),
    .o_data           (o_data),
    .o_last           (o_last),
    .o_ready          (o_ready),
    .busy             (busy),
    .done             (done)
  );

  // Buffer model: 1-clk read latency, garbage when not reading.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) buf_o_data <= rd_elem_req ? mem[rd_elem_idx] : 8'hEE;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event-not-as-expected expected scoreboard/timing match (cycle %0d)", name, cyc);
  endtask

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } exp_t;
  exp_t sbq[$];

  int   t0, rel, exp_idx, iss_cnt, acc_cnt, done_rel;
  bit   saw_busy, saw_valid, coll_on;
  bit   stall_prev;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  initial begin
    exp_t e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (sw_rst) begin
        stall_prev = 1'b0;
      end else begin
        if (o_valid && o_ready) begin
          acc_cnt++;
          if (sbq.size() == 0) flag_fail("unexpected_output");
          else begin
            e = sbq.pop_front();
            chk("out_data", 32'(o_data), 32'(e.d));
            chk("out_last", 32'(o_last), 32'(e.l));
          end
        end
        if (stall_prev) begin
          chk("hold_valid", 32'(o_valid), 32'd1);
          chk("hold_data", 32'(o_data), 32'(prev_data));
          chk("hold_last", 32'(o_last), 32'(prev_last));
        end
        stall_prev = o_valid && !o_ready && !abort;
        prev_data  = o_data;
        prev_last  = o_last;
        if (rd_elem_req) begin
          chk("rd_idx", 32'(rd_elem_idx), 32'(exp_idx));
          exp_idx = REV ? exp_idx - 1 : exp_idx + 1;
          iss_cnt++;
        end
        if (buf_add_elem_req) chk("yield_to_writer", 32'(rd_elem_req), 32'd0);
        if (coll_on && rel == 5) chk("coll_resume", 32'(rd_elem_req), 32'd1);
        if (done && done_rel < 0) done_rel = cyc - t0;
        if (busy) saw_busy = 1'b1;
        if (o_valid) saw_valid = 1'b1;
      end
    end
  end

  task automatic prep_scan(input int n, input logic [7:0] base);
    exp_t e;
    for (int i = 0; i < n; i++) mem[i] = base + 8'(i);
    sbq.delete();
    for (int i = 0; i < n; i++) begin
      int j;
      j   = REV ? n - 1 - i : i;
      e.d = mem[j];
      e.l = (i == n - 1);
      sbq.push_back(e);
    end
    exp_idx   = REV ? n - 1 : 0;
    iss_cnt   = 0;
    acc_cnt   = 0;
    done_rel  = -1;
    saw_busy  = 1'b0;
    saw_valid = 1'b0;
  endtask

  task automatic run_scan(input int n, input logic [7:0] base, input bit bp,
                          input bit coll, input int exp_done);
    int k;
    prep_scan(n, base);
    @(posedge clk); #1;
    buf_fullness = DEPTH_W'(n);
    start        = 1'b1;
    t0           = cyc;
    rel          = 0;
    coll_on      = coll;
    k            = 0;
    while (done_rel < 0 && k < 400) begin
      @(posedge clk); #1;
      rel              = cyc - t0;
      start            = bp && (rel == 4);  // must be ignored while busy
      buf_fullness     = DEPTH_W'(3);
      o_ready          = bp ? (rel % 2 == 1) : 1'b1;
      buf_add_elem_req = coll && (rel == 3 || rel == 4);
      k++;
    end
    start            = 1'b0;
    o_ready          = 1'b1;
    buf_add_elem_req = 1'b0;
    coll_on          = 1'b0;
    if (done_rel < 0) flag_fail("done_timeout");
    else if (exp_done >= 0) chk("done_latency", 32'(done_rel), 32'(exp_done));
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("issue_count", 32'(iss_cnt), 32'(n));
    chk("idle_after_done", 32'(busy), 32'd0);
    if (n == 0) begin
      chk("zero_no_busy", 32'(saw_busy), 32'd0);
      chk("zero_no_valid", 32'(saw_valid), 32'd0);
    end
  endtask

  typedef struct {
    int         n;
    logic [7:0] base;
    bit         bp;
    bit         coll;
    int         exp_done;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int k;
    tbl[0] = '{5,   8'h10, 1'b0, 1'b0, 7};
    tbl[1] = '{8,   8'h60, 1'b1, 1'b0, -1};
    tbl[2] = '{5,   8'h20, 1'b0, 1'b1, 9};
    tbl[3] = '{0,   8'h00, 1'b0, 1'b0, 1};
    tbl[4] = '{1,   8'h33, 1'b0, 1'b0, 3};
    tbl[5] = '{3,   8'hA0, 1'b0, 1'b0, 5};
    tbl[6] = '{100, 8'h00, 1'b0, 1'b0, 102};

    sw_rst = 1'b1; start = 1'b0; abort = 1'b0; buf_add_elem_req = 1'b0;
    o_ready = 1'b1; buf_fullness = '0; coll_on = 1'b0; rel = 0; done_rel = -1;
    exp_idx = 0; iss_cnt = 0; acc_cnt = 0; t0 = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_req", 32'(rd_elem_req), 32'd0);
    chk("rst_rd_idx", 32'(rd_elem_idx), 32'd0);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    sw_rst = 1'b0;

    foreach (tbl[i]) run_scan(tbl[i].n, tbl[i].base, tbl[i].bp, tbl[i].coll, tbl[i].exp_done);

    // Abort after four accepted outputs, then a clean rescan.
    prep_scan(10, 8'h40);
    @(posedge clk); #1;
    buf_fullness = DEPTH_W'(10);
    start        = 1'b1;
    t0           = cyc;
    k            = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end while (acc_cnt < 4 && k < 100);
    if (acc_cnt < 4) flag_fail("abort_wait_timeout");
    abort   = 1'b1;
    o_ready = 1'b0;
    @(posedge clk); #1;
    abort   = 1'b0;
    o_ready = 1'b1;
    sbq.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_valid", 32'(o_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(done_rel), 32'hFFFF_FFFF);
    run_scan(10, 8'h40, 1'b0, 1'b0, 12);

    // Reset in the middle of a scan.
    prep_scan(10, 8'h50);
    @(posedge clk); #1;
    buf_fullness = DEPTH_W'(10);
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    sbq.delete();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_rd_req", 32'(rd_elem_req), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    run_scan(4, 8'h70, 1'b0, 1'b0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
